// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, size masks,
// FSM state type and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Byte-lane mask of an access before it is shifted by the byte offset.
    // Illegal encodings give an empty mask so they never produce a strobe.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return MASK_B;
            F3_H, F3_HU: return MASK_H;
            F3_W:        return MASK_W;
            default:     return 4'b0000;
        endcase
    endfunction

    // Stores only know B/H/W; loads additionally accept the unsigned forms.
    function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
        if (write)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and word-memory signals of the load/store unit.
// slave is the unit itself; master is the pipeline plus memory side.
interface lsu_if #(
    parameter int ADDR_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_read, mem_write, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_read, mem_write, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store data/strobes across a word pair, and
// load data realignment plus sign/zero extension from a word pair.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [7:0]  strb,
    output logic [63:0] lane_data,
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    output logic [31:0] rdata
);
    logic [3:0]  mask;
    logic [31:0] wmask;
    logic [31:0] shifted;

    // Store side: trim data to the access size so unstrobed lanes stay zero.
    always_comb begin
        mask      = size_mask(funct3);
        wmask     = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        strb      = {4'b0000, mask} << off;
        lane_data = {32'b0, wdata & wmask} << {off, 3'b000};
    end

    // Load side: bring the addressed bytes down to bit 0 and extend.
    always_comb begin
        shifted = 32'({w1, w0} >> {off, 3'b000});
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = shifted;
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            default: rdata = 32'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RV32I loads/stores into one or two
// word accesses with byte strobes and returns a single-cycle response.
//
//   state | meaning
//   IDLE  | ready for a request
//   ACC0  | access to word A on the memory port
//   ACC1  | access to word A+1 (boundary-straddling access only)
//   WAIT  | last read word arrives, response data is formed
//   RESP  | resp_valid pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W           = 16,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    lsu_state_e        state;
    logic              r_write;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_split;
    logic [31:0]       r_w0;

    logic              idle;
    logic              accept;
    logic [2:0]        al_funct3;
    logic [1:0]        al_off;
    logic [31:0]       al_wdata;
    logic [7:0]        al_strb;
    logic [63:0]       al_lane;
    logic [31:0]       ld_w0;
    logic [31:0]       ld_w1;
    logic [31:0]       ld_rdata;
    logic              req_split;
    logic              req_err;
    logic              unused_addr_hi;

    assign idle          = (state == ST_IDLE);
    assign bus.req_ready = idle & ~rst;
    assign accept        = bus.req_valid & bus.req_ready;

    // The aligner sees the live request while idle (to set up the first
    // access at the accept edge) and the registered request afterwards.
    assign al_funct3 = idle ? bus.req_funct3   : r_funct3;
    assign al_off    = idle ? bus.req_addr[1:0] : r_off;
    assign al_wdata  = idle ? bus.req_wdata    : r_wdata;

    // For a split load the first word was captured in ACC1; otherwise the
    // word on mem_rdata is the only one.
    assign ld_w0 = r_split ? r_w0 : bus.mem_rdata;
    assign ld_w1 = r_split ? bus.mem_rdata : 32'b0;

    lsu_align u_align (
        .funct3    (al_funct3),
        .off       (al_off),
        .wdata     (al_wdata),
        .strb      (al_strb),
        .lane_data (al_lane),
        .w0        (ld_w0),
        .w1        (ld_w1),
        .rdata     (ld_rdata)
    );

    assign req_split = (al_strb[7:4] != 4'b0000);
    assign req_err   = !funct3_legal(bus.req_write, bus.req_funct3) ||
                       (!ALLOW_MISALIGNED && req_split);

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    // Sequencer with registered memory strobes and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            r_write        <= 1'b0;
            r_funct3       <= 3'b000;
            r_off          <= 2'b00;
            r_wdata        <= 32'b0;
            r_addr         <= '0;
            r_split        <= 1'b0;
            r_w0           <= 32'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wstrb  <= 4'b0000;
            bus.mem_wdata  <= 32'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'b0;
        end else begin
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wstrb  <= 4'b0000;
            bus.mem_wdata  <= 32'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        r_write  <= bus.req_write;
                        r_funct3 <= bus.req_funct3;
                        r_off    <= bus.req_addr[1:0];
                        r_wdata  <= bus.req_wdata;
                        r_addr   <= bus.req_addr[ADDR_W+1:2];
                        r_split  <= req_split;
                        if (req_err) begin
                            state          <= ST_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else begin
                            state         <= ST_ACC0;
                            bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
                            bus.mem_read  <= ~bus.req_write;
                            bus.mem_write <= bus.req_write;
                            if (bus.req_write) begin
                                bus.mem_wstrb <= al_strb[3:0];
                                bus.mem_wdata <= al_lane[31:0];
                            end
                        end
                    end
                end
                ST_ACC0: begin
                    if (r_split) begin
                        state         <= ST_ACC1;
                        bus.mem_addr  <= r_addr + ADDR_W'(1);
                        bus.mem_read  <= ~r_write;
                        bus.mem_write <= r_write;
                        if (r_write) begin
                            bus.mem_wstrb <= al_strb[7:4];
                            bus.mem_wdata <= al_lane[63:32];
                        end
                    end else if (!r_write) begin
                        state <= ST_WAIT;
                    end else begin
                        state          <= ST_RESP;
                        bus.resp_valid <= 1'b1;
                    end
                end
                ST_ACC1: begin
                    if (!r_write) begin
                        r_w0  <= bus.mem_rdata;
                        state <= ST_WAIT;
                    end else begin
                        state          <= ST_RESP;
                        bus.resp_valid <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    state          <= ST_RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= ld_rdata;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of requests with hand-computed
// responses and memory-port activity, plus reset and throughput sequences.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(16)) bus ();
    lsu_if #(.ADDR_W(16)) bus_na ();

    load_store_unit #(.ADDR_W(16), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    load_store_unit #(.ADDR_W(16), .ALLOW_MISALIGNED(1'b0)) dut_na (
        .clk (clk),
        .rst (rst),
        .bus (bus_na.slave)
    );

    // Shared request drivers, routed to one of the two units.
    logic        use_na = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    assign bus.req_valid     = req_valid & ~use_na;
    assign bus.req_write     = req_write;
    assign bus.req_funct3    = req_funct3;
    assign bus.req_addr      = req_addr;
    assign bus.req_wdata     = req_wdata;
    assign bus_na.req_valid  = req_valid & use_na;
    assign bus_na.req_write  = req_write;
    assign bus_na.req_funct3 = req_funct3;
    assign bus_na.req_addr   = req_addr;
    assign bus_na.req_wdata  = req_wdata;
    assign bus_na.mem_rdata  = 32'hA5A55A5A;

    wire        o_ready  = use_na ? bus_na.req_ready  : bus.req_ready;
    wire        o_rvalid = use_na ? bus_na.resp_valid : bus.resp_valid;
    wire        o_rerr   = use_na ? bus_na.resp_err   : bus.resp_err;
    wire [31:0] o_rdata  = use_na ? bus_na.resp_rdata : bus.resp_rdata;
    wire        o_mrd    = use_na ? bus_na.mem_read   : bus.mem_read;
    wire        o_mwr    = use_na ? bus_na.mem_write  : bus.mem_write;
    wire [15:0] o_maddr  = use_na ? bus_na.mem_addr   : bus.mem_addr;
    wire [3:0]  o_mstrb  = use_na ? bus_na.mem_wstrb  : bus.mem_wstrb;
    wire [31:0] o_mwdata = use_na ? bus_na.mem_wdata  : bus.mem_wdata;

    // Word memory behind the main unit; unwritten words read as zero.
    logic [31:0] mem [int];
    logic [31:0] mem_word;
    initial bus.mem_rdata = 32'h0;
    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem_word = mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (bus.mem_wstrb[b]) mem_word[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            mem[int'(bus.mem_addr)] = mem_word;
        end
        if (bus.mem_read)
            bus.mem_rdata <= mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)] : 32'h0;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          na;
        bit          write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
        int          lat;
        bit          split;
        logic [15:0] a0;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic [15:0] a1;
        logic [3:0]  s1;
        logic [31:0] d1;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic run_vec(input vec_t v, input int idx);
        int          n;
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic [1:0]  rw1, rw2;
        logic [15:0] ad1, ad2;
        logic [3:0]  st1, st2;
        logic [31:0] wd1, wd2;
        lat = 0; err = 1'b0; rd = 32'h0;
        rw1 = 2'b00; rw2 = 2'b00; ad1 = 16'h0; ad2 = 16'h0;
        st1 = 4'h0; st2 = 4'h0; wd1 = 32'h0; wd2 = 32'h0;

        @(negedge clk);
        use_na = v.na;
        #1;
        n = 0;
        while (!o_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d ready", idx), {31'b0, o_ready}, 32'h1);
        req_write  = v.write;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rw1 = {o_mrd, o_mwr}; ad1 = o_maddr; st1 = o_mstrb; wd1 = o_mwdata;
                req_valid  = 1'b0;
                req_write  = ~v.write;
                req_funct3 = 3'b111;
                req_addr   = 32'hFFFF_FFFC;
                req_wdata  = 32'h0BAD_F00D;
            end
            if (k == 2) begin
                rw2 = {o_mrd, o_mwr}; ad2 = o_maddr; st2 = o_mstrb; wd2 = o_mwdata;
            end
            if (o_rvalid) begin
                lat = k; err = o_rerr; rd = o_rdata;
                break;
            end
        end

        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d resp_err", idx), {31'b0, err}, {31'b0, v.err});
        chk($sformatf("v%0d resp_rdata", idx), rd, v.rdata);
        if (v.err) begin
            chk($sformatf("v%0d no_access", idx), {30'b0, rw1}, 32'h0);
        end else begin
            chk($sformatf("v%0d acc0_rw", idx), {30'b0, rw1}, {30'b0, ~v.write, v.write});
            chk($sformatf("v%0d acc0_addr", idx), {16'b0, ad1}, {16'b0, v.a0});
            chk($sformatf("v%0d acc0_wstrb", idx), {28'b0, st1}, {28'b0, v.s0});
            chk($sformatf("v%0d acc0_wdata", idx), wd1, v.d0);
            if (v.split) begin
                chk($sformatf("v%0d acc1_rw", idx), {30'b0, rw2}, {30'b0, ~v.write, v.write});
                chk($sformatf("v%0d acc1_addr", idx), {16'b0, ad2}, {16'b0, v.a1});
                chk($sformatf("v%0d acc1_wstrb", idx), {28'b0, st2}, {28'b0, v.s1});
                chk($sformatf("v%0d acc1_wdata", idx), wd2, v.d1);
            end else begin
                chk($sformatf("v%0d no_acc1", idx), {30'b0, rw2}, 32'h0);
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d resp_pulse_end", idx), {31'b0, o_rvalid}, 32'h0);
    endtask

    initial begin
        int idle_resp;
        //          na w  f3      addr          wdata         err rdata         lat sp a0       s0     d0            a1       s1     d1
        vecs[0]  = '{0, 1, 3'b010, 32'h00000100, 32'hDEADBEEF, 0, 32'h00000000, 2, 0, 16'h0040, 4'hF, 32'hDEADBEEF, 16'h0000, 4'h0, 32'h0};
        vecs[1]  = '{0, 0, 3'b010, 32'h00000100, 32'h00000000, 0, 32'hDEADBEEF, 3, 0, 16'h0040, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[2]  = '{0, 0, 3'b001, 32'h00000100, 32'h00000000, 0, 32'hFFFFBEEF, 3, 0, 16'h0040, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[3]  = '{0, 1, 3'b000, 32'h00000103, 32'hABCDEF80, 0, 32'h00000000, 2, 0, 16'h0040, 4'h8, 32'h80000000, 16'h0000, 4'h0, 32'h0};
        vecs[4]  = '{0, 0, 3'b000, 32'h00000103, 32'h00000000, 0, 32'hFFFFFF80, 3, 0, 16'h0040, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[5]  = '{0, 0, 3'b100, 32'h00000103, 32'h00000000, 0, 32'h00000080, 3, 0, 16'h0040, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[6]  = '{0, 1, 3'b000, 32'h00000200, 32'h12345655, 0, 32'h00000000, 2, 0, 16'h0080, 4'h1, 32'h00000055, 16'h0000, 4'h0, 32'h0};
        vecs[7]  = '{0, 0, 3'b100, 32'h00000200, 32'h00000000, 0, 32'h00000055, 3, 0, 16'h0080, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[8]  = '{0, 1, 3'b010, 32'h00000102, 32'h11223344, 0, 32'h00000000, 3, 1, 16'h0040, 4'hC, 32'h33440000, 16'h0041, 4'h3, 32'h00001122};
        vecs[9]  = '{0, 0, 3'b010, 32'h00000102, 32'h00000000, 0, 32'h11223344, 4, 1, 16'h0040, 4'h0, 32'h00000000, 16'h0041, 4'h0, 32'h0};
        vecs[10] = '{0, 0, 3'b101, 32'h00000102, 32'h00000000, 0, 32'h00003344, 3, 0, 16'h0040, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[11] = '{0, 1, 3'b001, 32'h00000103, 32'hAAAA9A78, 0, 32'h00000000, 3, 1, 16'h0040, 4'h8, 32'h78000000, 16'h0041, 4'h1, 32'h0000009A};
        vecs[12] = '{0, 0, 3'b001, 32'h00000103, 32'h00000000, 0, 32'hFFFF9A78, 4, 1, 16'h0040, 4'h0, 32'h00000000, 16'h0041, 4'h0, 32'h0};
        vecs[13] = '{0, 0, 3'b010, 32'h00000101, 32'h00000000, 0, 32'h9A7844BE, 4, 1, 16'h0040, 4'h0, 32'h00000000, 16'h0041, 4'h0, 32'h0};
        vecs[14] = '{0, 1, 3'b010, 32'h0003FFFC, 32'hCAFEF00D, 0, 32'h00000000, 2, 0, 16'hFFFF, 4'hF, 32'hCAFEF00D, 16'h0000, 4'h0, 32'h0};
        vecs[15] = '{0, 1, 3'b010, 32'h00000000, 32'h12345681, 0, 32'h00000000, 2, 0, 16'h0000, 4'hF, 32'h12345681, 16'h0000, 4'h0, 32'h0};
        vecs[16] = '{0, 0, 3'b001, 32'h0003FFFF, 32'h00000000, 0, 32'hFFFF81CA, 4, 1, 16'hFFFF, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[17] = '{0, 0, 3'b011, 32'h00000100, 32'h00000000, 1, 32'h00000000, 1, 0, 16'h0000, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[18] = '{0, 0, 3'b110, 32'h00000100, 32'h00000000, 1, 32'h00000000, 1, 0, 16'h0000, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[19] = '{0, 1, 3'b100, 32'h00000103, 32'h00000077, 1, 32'h00000000, 1, 0, 16'h0000, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[20] = '{0, 1, 3'b011, 32'h00000100, 32'h00000077, 1, 32'h00000000, 1, 0, 16'h0000, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[21] = '{0, 0, 3'b100, 32'h0003FFFF, 32'h00000000, 0, 32'h000000CA, 3, 0, 16'hFFFF, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[22] = '{1, 0, 3'b010, 32'h00000101, 32'h00000000, 1, 32'h00000000, 1, 0, 16'h0000, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[23] = '{1, 0, 3'b010, 32'h00000100, 32'h00000000, 0, 32'hA5A55A5A, 3, 0, 16'h0040, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[24] = '{1, 0, 3'b001, 32'h00000103, 32'h00000000, 1, 32'h00000000, 1, 0, 16'h0000, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};
        vecs[25] = '{1, 0, 3'b001, 32'h00000102, 32'h00000000, 0, 32'hFFFFA5A5, 3, 0, 16'h0040, 4'h0, 32'h00000000, 16'h0000, 4'h0, 32'h0};

        // Reset state of both units.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready", {31'b0, bus.req_ready}, 32'h0);
        chk("rst resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("rst mem_strobes", {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
        chk("rst na ready", {31'b0, bus_na.req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst ready", {31'b0, bus.req_ready}, 32'h1);
        chk("post_rst na ready", {31'b0, bus_na.req_ready}, 32'h1);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Back-to-back errors: a request accepted every second cycle.
        use_na = 1'b0;
        @(negedge clk);
        req_write = 1'b0; req_funct3 = 3'b111; req_addr = 32'h0; req_valid = 1'b1;
        @(negedge clk);
        chk("b2b resp1", {30'b0, bus.resp_valid, bus.resp_err}, 32'h3);
        @(negedge clk);
        chk("b2b ready", {31'b0, bus.req_ready}, 32'h1);
        @(negedge clk);
        chk("b2b resp2", {30'b0, bus.resp_valid, bus.resp_err}, 32'h3);
        req_valid = 1'b0;
        @(negedge clk);

        // Reset while the second half of a split store is on the bus.
        req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h102;
        req_wdata = 32'h55667788; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort acc1_write", {31'b0, bus.mem_write}, 32'h1);
        chk("abort acc1_addr", {16'b0, bus.mem_addr}, 32'h41);
        rst = 1'b1;
        @(negedge clk);
        chk("abort no_write", {30'b0, bus.mem_write, bus.mem_read}, 32'h0);
        chk("abort no_resp", {31'b0, bus.resp_valid}, 32'h0);
        chk("abort ready_low", {31'b0, bus.req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort ready_back", {31'b0, bus.req_ready}, 32'h1);
        idle_resp = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.resp_valid || bus.mem_write || bus.mem_read) idle_resp++;
            @(negedge clk);
        end
        chk("abort stays_idle", idle_resp, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
